// File: rtl/dsp_fe_pkg.sv
// ============================================================================
// Module      : dsp_fe_pkg
// Description : Shared types and helpers for the DSP frontend snapshot buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_fe_pkg;

  // Default frame geometry. The snapshot top re-derives these from its own
  // parameters; these values size the shared frame_t type.
  localparam int LANE_WIDTH_DEF    = 16;
  localparam int DES_OUT_WIDTH_DEF = 4;
  localparam int ADC_WIDTH_DEF     = 6;
  localparam int DEPTH_DEF         = 64;
  localparam int FRAME_SAMPLES     = LANE_WIDTH_DEF * DES_OUT_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } snap_state_e;

  typedef logic [ADC_WIDTH_DEF-1:0] sample_t;
  typedef sample_t [FRAME_SAMPLES-1:0] frame_t;

  // Post-trigger depth is capped so the trigger frame can never be overwritten.
  function automatic int unsigned cap_post(input int unsigned req, input int unsigned depth);
    return (req > depth - 1) ? depth - 1 : req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer followed by a registered rising-edge
//               detector. Input edge to pulse is three clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_pulse;

  // Synchronize, then register a one-cycle pulse on each rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_async};
      r_prev  <= r_sync[1];
      r_pulse <= r_sync[1] & ~r_prev;
    end
  end

  // Level is taken from the stage aligned with the pulse, so it is already
  // high on the cycle the pulse is seen.
  assign o_level = r_prev;
  assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/dsp_fe_snapshot.sv
// ============================================================================
// Module      : dsp_fe_snapshot
// Description : Ring-buffer capture of DSP frontend frames with software or
//               amplitude-threshold trigger, programmable post-trigger depth
//               and a random-access readout port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_fe_snapshot
  import dsp_fe_pkg::*;
#(
  parameter int  LANE_WIDTH    = 16,
  parameter int  DES_OUT_WIDTH = 4,
  parameter int  ADC_WIDTH     = 6,
  parameter int  DEPTH         = 64,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                                                i_clk_dig_mem,
  input  logic                                                i_rstb_dig_mem,
  input  logic [LANE_WIDTH*DES_OUT_WIDTH-1:0][ADC_WIDTH-1:0]  i_dat_fe,
  input  logic                                                i_arm,
  input  logic                                                i_trig_sw,
  input  logic                                                i_thr_en,
  input  logic [ADC_WIDTH-1:0]                                i_thr_hi,
  input  logic [ADC_WIDTH-1:0]                                i_thr_lo,
  input  logic [AW-1:0]                                       i_post_cnt,
  input  logic [AW-1:0]                                       i_rd_addr,
  output logic [LANE_WIDTH*DES_OUT_WIDTH-1:0][ADC_WIDTH-1:0]  o_rd_dat,
  output logic                                                o_busy,
  output logic                                                o_done,
  output logic [AW-1:0]                                       o_trig_addr,
  output logic [AW-1:0]                                       o_last_addr,
  output logic                                                o_wrapped
);

  localparam int N_SAMP = LANE_WIDTH * DES_OUT_WIDTH;

  typedef logic [N_SAMP-1:0][ADC_WIDTH-1:0] frame_w_t;

  frame_w_t    r_d_q;
  frame_w_t    r_mem [DEPTH];
  frame_w_t    r_rd_dat;

  snap_state_e r_state,     w_state_nxt;
  logic [AW-1:0] r_wr_ptr,    w_wr_ptr_nxt;
  logic [AW-1:0] r_post_rem,  w_post_rem_nxt;
  logic [AW-1:0] r_trig_addr, w_trig_addr_nxt;
  logic [AW-1:0] r_last_addr, w_last_addr_nxt;
  logic          r_wrapped,   w_wrapped_nxt;
  logic          r_done;
  logic          r_busy;
  logic          w_wr_en;

  logic          w_arm_lvl;
  logic          w_arm_p;
  logic          w_trig_lvl_unused;
  logic          w_trig_p;
  logic          w_any_hi;
  logic          w_any_lo;
  logic          w_thr_hit;
  logic          w_trig;
  logic [AW-1:0] w_post_cap;

  sync_edge u_sync_arm (
    .i_clk   (i_clk_dig_mem),
    .i_rst_n (i_rstb_dig_mem),
    .i_async (i_arm),
    .o_level (w_arm_lvl),
    .o_pulse (w_arm_p)
  );

  sync_edge u_sync_trig (
    .i_clk   (i_clk_dig_mem),
    .i_rst_n (i_rstb_dig_mem),
    .i_async (i_trig_sw),
    .o_level (w_trig_lvl_unused),
    .o_pulse (w_trig_p)
  );

  // Input stage: one register between the frontend and the write/threshold path.
  always_ff @(posedge i_clk_dig_mem or negedge i_rstb_dig_mem) begin
    if (!i_rstb_dig_mem) r_d_q <= '0;
    else                 r_d_q <= i_dat_fe;
  end

  // Unsigned amplitude check of every sample in the registered frame.
  always_comb begin
    w_any_hi = 1'b0;
    w_any_lo = 1'b0;
    for (int k = 0; k < N_SAMP; k++) begin
      if (r_d_q[k] >= i_thr_hi) w_any_hi = 1'b1;
      if (r_d_q[k] <= i_thr_lo) w_any_lo = 1'b1;
    end
  end

  assign w_thr_hit  = i_thr_en & (w_any_hi | w_any_lo);
  assign w_trig     = w_trig_p | w_thr_hit;
  assign w_post_cap = AW'(cap_post(32'(i_post_cnt), DEPTH));

  // Next-state, pointer and status computation for the capture sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_post_rem_nxt  = r_post_rem;
    w_trig_addr_nxt = r_trig_addr;
    w_last_addr_nxt = r_last_addr;
    w_wrapped_nxt   = r_wrapped;
    w_wr_en         = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (w_arm_p) begin
          w_state_nxt   = ARMED;
          w_wr_ptr_nxt  = '0;
          w_wrapped_nxt = 1'b0;
        end
      end
      ARMED, POST: begin
        if (!w_arm_lvl) begin
          // Abort: stop recording, leave captured data in place.
          w_state_nxt = IDLE;
        end else begin
          w_wr_en         = 1'b1;
          w_last_addr_nxt = r_wr_ptr;
          w_wr_ptr_nxt    = r_wr_ptr + 1'b1;
          if (r_wr_ptr == AW'(DEPTH - 1)) w_wrapped_nxt = 1'b1;
          if (r_state == ARMED) begin
            if (w_trig) begin
              w_trig_addr_nxt = r_wr_ptr;
              w_post_rem_nxt  = w_post_cap;
              w_state_nxt     = (w_post_cap == '0) ? DONE : POST;
            end
          end else begin
            w_post_rem_nxt = r_post_rem - 1'b1;
            if (r_post_rem == AW'(1)) w_state_nxt = DONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequencer state and status registers; busy/done track the next state.
  always_ff @(posedge i_clk_dig_mem or negedge i_rstb_dig_mem) begin
    if (!i_rstb_dig_mem) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_post_rem  <= '0;
      r_trig_addr <= '0;
      r_last_addr <= '0;
      r_wrapped   <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_post_rem  <= w_post_rem_nxt;
      r_trig_addr <= w_trig_addr_nxt;
      r_last_addr <= w_last_addr_nxt;
      r_wrapped   <= w_wrapped_nxt;
      r_done      <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt == ARMED) || (w_state_nxt == POST);
    end
  end

  // Frame store write port; contents are intentionally not reset.
  always_ff @(posedge i_clk_dig_mem) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_d_q;
  end

  // Registered readout, available in every state.
  always_ff @(posedge i_clk_dig_mem or negedge i_rstb_dig_mem) begin
    if (!i_rstb_dig_mem) r_rd_dat <= '0;
    else                 r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat    = r_rd_dat;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_trig_addr = r_trig_addr;
  assign o_last_addr = r_last_addr;
  assign o_wrapped   = r_wrapped;

endmodule

`default_nettype wire
